// File: rtl/long_latency_scoreboard_pkg.sv
// Shared types and constants for the long-latency register scoreboard.
package long_latency_scoreboard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned NUM_REGS   = 32;

    localparam logic [REG_ADDR_W-1:0] X0 = '0;

    typedef enum logic {
        SB_IDLE  = 1'b0,
        SB_DRAIN = 1'b1
    } sb_state_e;

endpackage

// File: rtl/long_latency_scoreboard_if.sv
// ID-stage issue, out-of-band write-back and stall/bypass signals of the scoreboard.
interface long_latency_scoreboard_if
    import long_latency_scoreboard_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4
) ();

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    logic                  issue_valid;
    logic [REG_ADDR_W-1:0] issue_rs1;
    logic [REG_ADDR_W-1:0] issue_rs2;
    logic                  issue_use_rs1;
    logic                  issue_use_rs2;
    logic [REG_ADDR_W-1:0] issue_rd;
    logic                  issue_reg_write;
    logic                  issue_long;
    logic                  issue_drain;
    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  stall;
    logic                  wb_bypass_rs1;
    logic                  wb_bypass_rs2;
    logic [NUM_REGS-1:0]   busy;
    logic [CNT_W-1:0]      inflight_count;

    modport master (
        output issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_rd, issue_reg_write, issue_long, issue_drain, wb_valid, wb_rd,
        input  stall, wb_bypass_rs1, wb_bypass_rs2, busy, inflight_count
    );

    modport slave (
        input  issue_valid, issue_rs1, issue_rs2, issue_use_rs1, issue_use_rs2,
               issue_rd, issue_reg_write, issue_long, issue_drain, wb_valid, wb_rd,
        output stall, wb_bypass_rs1, wb_bypass_rs2, busy, inflight_count
    );

endinterface

// File: rtl/long_latency_scoreboard_sb_operand_check.sv
// Per-operand RAW hazard and write-back bypass evaluation against the pending vector.
module long_latency_scoreboard_sb_operand_check
    import long_latency_scoreboard_pkg::*;
(
    input  logic                  i_use,
    input  logic [REG_ADDR_W-1:0] i_rs,
    input  logic [NUM_REGS-1:0]   i_busy,
    input  logic                  i_wb_hit,
    input  logic [REG_ADDR_W-1:0] i_wb_rd,
    output logic                  o_raw,
    output logic                  o_bypass
);

    logic w_live;
    logic w_wb_match;

    assign w_live     = i_use && (i_rs != X0);
    // A write-back landing this cycle satisfies the operand through the bypass.
    assign w_wb_match = i_wb_hit && (i_wb_rd == i_rs);
    assign o_raw      = w_live && i_busy[i_rs] && !w_wb_match;
    assign o_bypass   = w_live && w_wb_match;

endmodule

// File: rtl/long_latency_scoreboard.sv
// Tracks pending long-latency destination registers and decides ID-stage stalls and
// same-cycle write-back bypasses.
module long_latency_scoreboard
    import long_latency_scoreboard_pkg::*;
#(
    parameter int unsigned MAX_INFLIGHT = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    long_latency_scoreboard_if.slave  sb
);

    localparam int unsigned CNT_W = $clog2(MAX_INFLIGHT + 1);

    sb_state_e           r_state;
    logic [NUM_REGS-1:0] r_busy;
    logic [CNT_W-1:0]    r_count;

    logic                w_wb_hit;
    logic                w_raw1;
    logic                w_raw2;
    logic                w_byp1;
    logic                w_byp2;
    logic                w_waw;
    logic                w_full;
    logic                w_drn;
    logic                w_stall;
    logic                w_set;
    logic [NUM_REGS-1:0] w_set_mask;
    logic [NUM_REGS-1:0] w_clr_mask;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [CNT_W-1:0]    w_count_nxt;

    // Write-backs to registers that are not pending are ignored.
    assign w_wb_hit = sb.wb_valid && r_busy[sb.wb_rd];

    long_latency_scoreboard_sb_operand_check u_rs1_check (
        .i_use    (sb.issue_use_rs1),
        .i_rs     (sb.issue_rs1),
        .i_busy   (r_busy),
        .i_wb_hit (w_wb_hit),
        .i_wb_rd  (sb.wb_rd),
        .o_raw    (w_raw1),
        .o_bypass (w_byp1)
    );

    long_latency_scoreboard_sb_operand_check u_rs2_check (
        .i_use    (sb.issue_use_rs2),
        .i_rs     (sb.issue_rs2),
        .i_busy   (r_busy),
        .i_wb_hit (w_wb_hit),
        .i_wb_rd  (sb.wb_rd),
        .o_raw    (w_raw2),
        .o_bypass (w_byp2)
    );

    assign w_waw  = sb.issue_reg_write && (sb.issue_rd != X0) && r_busy[sb.issue_rd]
                    && !(w_wb_hit && (sb.wb_rd == sb.issue_rd));
    // A retiring write-back frees a slot in the same cycle, so capacity never blocks then.
    assign w_full = sb.issue_long && sb.issue_reg_write && (sb.issue_rd != X0)
                    && (r_count == CNT_W'(MAX_INFLIGHT)) && !w_wb_hit;
    assign w_drn  = sb.issue_drain && (r_count != '0);

    always_comb begin
        w_stall = 1'b0;
        if (r_state == SB_DRAIN) begin
            w_stall = 1'b1;
        end else begin
            w_stall = sb.issue_valid && (w_raw1 || w_raw2 || w_waw || w_full || w_drn);
        end
    end

    assign w_set = sb.issue_valid && !w_stall && sb.issue_long && sb.issue_reg_write
                   && (sb.issue_rd != X0);

    // Set wins over clear when issue and write-back target the same register.
    always_comb begin
        w_set_mask  = '0;
        w_clr_mask  = '0;
        w_count_nxt = r_count;
        if (w_set) begin
            w_set_mask[sb.issue_rd] = 1'b1;
        end
        if (w_wb_hit) begin
            w_clr_mask[sb.wb_rd] = 1'b1;
        end
        w_busy_nxt = (r_busy & ~w_clr_mask) | w_set_mask;
        case ({w_set, w_wb_hit})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= SB_IDLE;
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            r_busy  <= w_busy_nxt;
            r_count <= w_count_nxt;
            case (r_state)
                SB_IDLE:  if (sb.issue_valid && w_drn) r_state <= SB_DRAIN;
                SB_DRAIN: if (r_count == '0) r_state <= SB_IDLE;
                default:  r_state <= SB_IDLE;
            endcase
        end
    end

    assign sb.stall          = w_stall;
    assign sb.wb_bypass_rs1  = w_byp1;
    assign sb.wb_bypass_rs2  = w_byp2;
    assign sb.busy           = r_busy;
    assign sb.inflight_count = r_count;

endmodule

// File: tb/tb_long_latency_scoreboard.sv
// Directed bench for long_latency_scoreboard with hand-computed expectations.
module tb_long_latency_scoreboard;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    long_latency_scoreboard_if #(.MAX_INFLIGHT(4)) sb_if ();

    long_latency_scoreboard #(.MAX_INFLIGHT(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                               input logic u2, input logic [4:0] rd, input logic rw,
                               input logic lng, input logic drn);
        sb_if.issue_valid     = 1'b1;
        sb_if.issue_rs1       = rs1;
        sb_if.issue_use_rs1   = u1;
        sb_if.issue_rs2       = rs2;
        sb_if.issue_use_rs2   = u2;
        sb_if.issue_rd        = rd;
        sb_if.issue_reg_write = rw;
        sb_if.issue_long      = lng;
        sb_if.issue_drain     = drn;
    endtask

    task automatic drive_wb(input logic v, input logic [4:0] rd);
        sb_if.wb_valid = v;
        sb_if.wb_rd    = rd;
    endtask

    task automatic clear_inputs();
        drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        sb_if.issue_valid = 1'b0;
        drive_wb(1'b0, 5'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] wb_list [4];
        n_checks = 0;
        n_errors = 0;
        wb_list  = '{5'd1, 5'd3, 5'd4, 5'd6};
        reset    = 1'b1;
        clear_inputs();
        #2;
        // Outputs stay quiet in reset regardless of inputs
        drive_issue(5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1);
        drive_wb(1'b1, 5'd5);
        #1;
        check("rst_busy", sb_if.busy, 32'h0);
        check("rst_count", 32'(sb_if.inflight_count), 32'd0);
        check("rst_stall", 32'(sb_if.stall), 32'd0);
        check("rst_byp1", 32'(sb_if.wb_bypass_rs1), 32'd0);
        check("rst_byp2", 32'(sb_if.wb_bypass_rs2), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        step();

        // Long load to x5, dependent add stalls until write-back bypass
        drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0);
        #1;
        check("ld_stall", 32'(sb_if.stall), 32'd0);
        step();
        check("ld_busy", sb_if.busy, 32'h0000_0020);
        check("ld_count", 32'(sb_if.inflight_count), 32'd1);
        drive_issue(5'd5, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0);
        #1;
        check("raw_stall", 32'(sb_if.stall), 32'd1);
        check("raw_byp1", 32'(sb_if.wb_bypass_rs1), 32'd0);
        step();
        check("raw_stall2", 32'(sb_if.stall), 32'd1);
        drive_issue(5'd5, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
        drive_wb(1'b1, 5'd5);
        #1;
        check("wb_stall", 32'(sb_if.stall), 32'd0);
        check("wb_byp1", 32'(sb_if.wb_bypass_rs1), 32'd1);
        check("wb_byp2", 32'(sb_if.wb_bypass_rs2), 32'd1);
        step();
        clear_inputs();
        #1;
        check("wb_busy", sb_if.busy, 32'h0);
        check("wb_count", 32'(sb_if.inflight_count), 32'd0);

        // Fill to capacity, then a retiring write-back lets the fifth in
        for (int i = 1; i <= 4; i++) begin
            drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'(i), 1'b1, 1'b1, 1'b0);
            #1;
            check("fill_stall", 32'(sb_if.stall), 32'd0);
            step();
        end
        clear_inputs();
        #1;
        check("fill_busy", sb_if.busy, 32'h0000_001E);
        check("fill_count", 32'(sb_if.inflight_count), 32'd4);
        drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0);
        #1;
        check("full_stall", 32'(sb_if.stall), 32'd1);
        drive_wb(1'b1, 5'd2);
        #1;
        check("full_wb_stall", 32'(sb_if.stall), 32'd0);
        step();
        clear_inputs();
        #1;
        check("full_busy", sb_if.busy, 32'h0000_005A);
        check("full_count", 32'(sb_if.inflight_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            drive_wb(1'b1, wb_list[i]);
            step();
        end
        drive_wb(1'b0, 5'd0);
        #1;
        check("empty_count", 32'(sb_if.inflight_count), 32'd0);

        // WAW on a short producer, released by the write-back of the same register
        drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
        step();
        drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        #1;
        check("waw_stall", 32'(sb_if.stall), 32'd1);
        step();
        drive_wb(1'b1, 5'd7);
        #1;
        check("waw_wb_stall", 32'(sb_if.stall), 32'd0);
        step();
        clear_inputs();
        #1;
        check("waw_busy", sb_if.busy, 32'h0);

        // x0 destination and sources never set busy, stall or bypass
        drive_issue(5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 1'b0);
        drive_wb(1'b1, 5'd0);
        #1;
        check("x0_stall", 32'(sb_if.stall), 32'd0);
        check("x0_byp1", 32'(sb_if.wb_bypass_rs1), 32'd0);
        step();
        clear_inputs();
        #1;
        check("x0_busy", sb_if.busy, 32'h0);
        check("x0_count", 32'(sb_if.inflight_count), 32'd0);

        // Drain with two pending write-backs
        drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1, 1'b0);
        step();
        drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd11, 1'b1, 1'b1, 1'b0);
        step();
        drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        check("drn_count", 32'(sb_if.inflight_count), 32'd2);
        check("drn_req_stall", 32'(sb_if.stall), 32'd1);
        step();
        drive_wb(1'b1, 5'd10);
        #1;
        check("drn_wb1_stall", 32'(sb_if.stall), 32'd1);
        step();
        drive_wb(1'b1, 5'd11);
        #1;
        check("drn_wb2_stall", 32'(sb_if.stall), 32'd1);
        check("drn_wb2_count", 32'(sb_if.inflight_count), 32'd1);
        step();
        drive_wb(1'b0, 5'd0);
        #1;
        check("drn_tail_count", 32'(sb_if.inflight_count), 32'd0);
        check("drn_tail_stall", 32'(sb_if.stall), 32'd1);
        step();
        check("drn_issue_stall", 32'(sb_if.stall), 32'd0);
        step();
        clear_inputs();

        // Write-back to a non-pending register changes nothing
        drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b1, 1'b0);
        step();
        clear_inputs();
        drive_wb(1'b1, 5'd9);
        step();
        drive_wb(1'b0, 5'd0);
        #1;
        check("ign_busy", sb_if.busy, 32'h0000_1000);
        check("ign_count", 32'(sb_if.inflight_count), 32'd1);

        // Reset in DRAIN with three pending clears everything at once
        drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1, 1'b0);
        step();
        drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd14, 1'b1, 1'b1, 1'b0);
        step();
        drive_issue(5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        #1;
        check("mid_count", 32'(sb_if.inflight_count), 32'd3);
        step();
        check("mid_drain_stall", 32'(sb_if.stall), 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", sb_if.busy, 32'h0);
        check("mid_rst_count", 32'(sb_if.inflight_count), 32'd0);
        check("mid_rst_stall", 32'(sb_if.stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        clear_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/long_latency_scoreboard.md
# long_latency_scoreboard

Register scoreboard for the pipelined RISC-V core. It tracks destination registers of long-latency producers (cache-miss loads, multi-cycle multiply/divide) that the EX/MEM/WB forwarding paths cannot cover. It decides ID-stage stalls (RAW, WAW, capacity, drain) and flags same-cycle write-back bypasses to the operand muxes. It sits beside the forwarding unit: forwarding consumes rd/RegWrite from pipeline registers, while this block owns writes that complete out of band.

## Interface
- MAX_INFLIGHT, 4, max outstanding long-latency writes (1..31)
- CNT_W, $clog2(MAX_INFLIGHT+1), width of inflight counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- issue_valid  in  1  ID holds an instruction requesting advance
- issue_rs1 / issue_rs2  in  5  source register indices
- issue_use_rs1 / issue_use_rs2  in  1  operand actually read
- issue_rd  in  5  destination index
- issue_reg_write  in  1  instruction writes rd
- issue_long  in  1  producer completes via wb port, not the pipeline
- issue_drain  in  1  instruction needs empty scoreboard (ecall, fence)
- wb_valid  in  1  long-latency result written this cycle
- wb_rd  in  5  index being written back
- stall  out  1  hold ID/IF this cycle
- wb_bypass_rs1 / wb_bypass_rs2  out  1  take operand from wb data bus
- busy  out  32  registered pending vector (bit 0 always 0)
- inflight_count  out  CNT_W  registered outstanding count

## Operation
- wb_hit = wb_valid && busy[wb_rd]; wb_valid on non-busy register ignored entirely.
- RAW_n = issue_use_rsn && rsn!=0 && busy[rsn] && !(wb_hit && wb_rd==rsn).
- WAW = issue_reg_write && rd!=0 && busy[rd] && !(wb_hit && wb_rd==rd); applies to short and long producers.
- FULL = issue_long && issue_reg_write && rd!=0 && count==MAX_INFLIGHT && !wb_hit.
- FSM IDLE/DRAIN. IDLE: DRN = issue_drain && count!=0; on issue_valid && DRN go DRAIN. DRAIN: stall forced 1; when registered count==0 return IDLE.
- stall = issue_valid && (RAW_1 || RAW_2 || WAW || FULL || DRN) in IDLE; 1 in DRAIN.
- wb_bypass_rsn = issue_use_rsn && rsn!=0 && wb_hit && wb_rd==rsn; independent of stall.
- accept = issue_valid && !stall. set = accept && issue_long && issue_reg_write && rd!=0.
- Next state: busy[rd] set by set; busy[wb_rd] cleared by wb_hit; same index both → stays set. count += set − wb_hit (both → unchanged).
- Invariant: inflight_count == popcount(busy) every cycle; count never exceeds MAX_INFLIGHT, never underflows.

## Timing
- Reset (async assert, sync release): busy=0, count=0, state IDLE; stall and bypasses then 0 for any input.
- stall and bypass combinational, same cycle as inputs; busy/count/state update on next rising edge.
- Write-back to dependent issue: zero cycles (bypass in wb cycle).
- Drain: stall from request cycle until the cycle after count reaches 0; drain instruction issues in first IDLE cycle.
- Reset mid-DRAIN or with pending busy: all state cleared; pipeline flush is the core's responsibility.

## Structure
- Shared package: REG_ADDR_W=5, NUM_REGS=32, X0 index, FSM state encodings SB_IDLE/SB_DRAIN.
- One sub-module natural: sb_operand_check (per-operand RAW/bypass evaluation, instantiated for rs1 and rs2).
- Single always block for busy/count/state with async reset; stall logic combinational.

## Test plan
- Issue long load rd=5; next cycle issue add rs1=5 → stall=1 until wb_valid, wb_rd=5, in which stall=0, wb_bypass_rs1=1; busy[5] 0 afterwards.
- Four long ops rd=1..4 with MAX_INFLIGHT=4, fifth long rd=6 → stall; same cycle wb_rd=2 → no stall, count stays 4, busy={1,3,4,6}.
- busy[7] set; issue short op rd=7 → WAW stall; rd=0 long/short ops never set busy or stall.
- Two pending, issue_drain → stall 1 through both write-backs plus one cycle, then issues; count=0, state IDLE.
- wb_valid wb_rd=9 while busy[9]=0 → no state change, count unchanged; reset asserted mid-DRAIN with 3 pending → busy=0, count=0, stall=0 immediately.
